// File: rtl/noc_traffic_sequencer.sv
// rtl/noc_traffic_sequencer.sv - run controller for the random-traffic PE mesh
// Arms PEs, pulses start, waits for done or timeout, drains, sums counters, checks total.
module noc_traffic_sequencer #(
  parameter int          X            = 2,
  parameter int          Y            = 2,
  parameter int          numPackets   = 100,
  parameter int unsigned TIMEOUT      = 100000,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              go,
  input  logic [X*Y-1:0]    enable_mask,
  input  logic              mesh_done,
  input  logic [32*X*Y-1:0] receive_count,
  output logic              start,
  output logic [X*Y-1:0]    enableSend,
  output logic              busy,
  output logic              finished,
  output logic              pass,
  output logic              timed_out,
  output logic [31:0]       cycle_count,
  output logic [31:0]       total_received,
  output logic [31:0]       expected_total
);

  localparam int N  = X * Y;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, SUM, CHECK, DONE} state_t;

  state_t         state;
  logic [N-1:0]   mask_q;
  logic [15:0]    drain_cnt;
  logic [IW-1:0]  sum_idx;
  logic [31:0]    pop_cnt;
  logic [31:0]    sel_count;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (mask_q[i]) pop_cnt = pop_cnt + 32'd1;
    end
  end

  // One PE counter per SUM cycle keeps the adder a single 32-bit stage.
  always_comb begin
    sel_count = '0;
    for (int i = 0; i < N; i++) begin
      if (sum_idx == IW'(i)) sel_count = receive_count[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      mask_q         <= '0;
      drain_cnt      <= '0;
      sum_idx        <= '0;
      start          <= 1'b0;
      enableSend     <= '0;
      busy           <= 1'b0;
      finished       <= 1'b0;
      pass           <= 1'b0;
      timed_out      <= 1'b0;
      cycle_count    <= '0;
      total_received <= '0;
      expected_total <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (go) begin
            mask_q         <= enable_mask;
            enableSend     <= enable_mask;
            cycle_count    <= '0;
            total_received <= '0;
            pass           <= 1'b0;
            timed_out      <= 1'b0;
            busy           <= 1'b1;
            finished       <= 1'b0;
            state          <= ARM;
          end
        end
        ARM: begin
          expected_total <= 32'(numPackets) * pop_cnt;
          start          <= 1'b1;
          state          <= RUN;
        end
        RUN: begin
          cycle_count <= cycle_count + 32'd1;
          if (mesh_done) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end else if (cycle_count == 32'(TIMEOUT - 1)) begin
            timed_out  <= 1'b1;
            enableSend <= '0;
            busy       <= 1'b0;
            finished   <= 1'b1;
            state      <= DONE;
          end
        end
        DRAIN: begin
          if (drain_cnt == 16'(DRAIN_CYCLES - 1)) begin
            enableSend <= '0;
            sum_idx    <= '0;
            state      <= SUM;
          end else begin
            drain_cnt <= drain_cnt + 16'd1;
          end
        end
        SUM: begin
          total_received <= total_received + sel_count;
          if (sum_idx == IW'(N - 1)) begin
            state <= CHECK;
          end else begin
            sum_idx <= sum_idx + IW'(1);
          end
        end
        CHECK: begin
          pass     <= (total_received == expected_total);
          busy     <= 1'b0;
          finished <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/noc_traffic_sequencer.md
# noc_traffic_sequencer

Run controller for the random-traffic PE mesh. Arms the selected PEs' `enableSend`, pulses `start` and waits for the mesh-wide `done`, with a cycle timeout. It then lets in-flight flits drain, serially sums the per-PE 32-bit received-packet counters, and flags pass/fail against the expected total. It sits between the testbench or host control and the PE mesh top, and drives every run of a traffic experiment.

## Interface
- `X`, 2: mesh columns.
- `Y`, 2: mesh rows.
- `numPackets`, 100: packets each enabled PE sends per run.
- `TIMEOUT`, 100000: maximum RUN cycles before abort. Range 1..2^32-1.
- `DRAIN_CYCLES`, 16: wait after `done` before counters are read. Range 1..2^16-1.

Ports:
- `clk`, in, 1: clock.
- `rstn`, in, 1: asynchronous active-low reset.
- `go`, in, 1: request a run. Sampled only in IDLE or DONE.
- `enable_mask`, in, X*Y: PEs allowed to send. Bit index is `x+X*y`. Latched on `go`.
- `mesh_done`, in, 1: AND of all PE done flags.
- `receive_count`, in, 32*X*Y: per-PE received count. PE i occupies bits `[32*i +: 32]`.
- `start`, out, 1: one-cycle start pulse to all PEs.
- `enableSend`, out, X*Y: per-PE send enable.
- `busy`, out, 1: high in every state except IDLE and DONE.
- `finished`, out, 1: high in DONE.
- `pass`, out, 1: valid when `finished`. High when the total equals expected and no timeout occurred.
- `timed_out`, out, 1: valid when `finished`.
- `cycle_count`, out, 32: number of RUN cycles in the last run.
- `total_received`, out, 32: sum of all `receive_count` values.
- `expected_total`, out, 32: `numPackets * popcount(mask)`.

## Operation
States: IDLE, ARM, RUN, DRAIN, SUM, CHECK, DONE.
- **IDLE / DONE, `go`=1:** latch `enable_mask`, clear `cycle_count`, `total_received`, `pass` and `timed_out`, then go to ARM. `go`=0 holds the current state. DONE keeps the previous results visible.
- **ARM** (1 cycle): drive `enableSend` = latched mask. Register `expected_total` = `numPackets` × popcount(mask), truncated to 32 bits. Go to RUN.
- **RUN:**
  - `start`=1 only in the first RUN cycle. `cycle_count` increments by 1 every RUN cycle.
  - `mesh_done`=1 goes to DRAIN.
  - Otherwise, when `cycle_count`==TIMEOUT−1, set `timed_out` and go to DONE, skipping DRAIN, SUM and CHECK. `pass`=0 and `total_received`=0.
  - If `mesh_done` and the timeout condition occur in the same cycle, `mesh_done` wins.
- **DRAIN:** a 16-bit counter runs for DRAIN_CYCLES cycles, then the block goes to SUM. `enableSend` is held through DRAIN and forced to 0 on SUM entry.
- **SUM:** index i runs 0..X*Y−1, one PE per cycle: `total_received` += `receive_count[i]`, modulo 2^32. After index X*Y−1 the block goes to CHECK. SUM therefore lasts exactly X*Y cycles.
- **CHECK** (1 cycle): `pass` = (`total_received` == `expected_total`). Go to DONE.
- **Empty mask (all zero):** the run still proceeds. `expected_total`=0, and `pass` is high if no packets arrive.
- **`go` while busy:** ignored, not queued.
- **Reset** asserted at any time, including mid-run: all state and outputs are forced asynchronously to reset values, the block returns to IDLE, and `start`/`enableSend` drop at once.

## Timing
- **Reset values:** state IDLE, `start`=0, `enableSend`=0, `busy`=0, `finished`=0, `pass`=0, `timed_out`=0, all counters and totals 0.
- **Start-up sequence:**
  - `go` sampled high at edge t: ARM during cycle t+1, with `enableSend` valid from t+1.
  - RUN from t+2, with `start` high for cycle t+2 only.
- **`cycle_count`** equals the number of RUN cycles spent, including the cycle in which `mesh_done` was sampled.
- **Normal-completion latency:** `mesh_done` sampled at edge d gives DRAIN from d+1 and SUM from d+1+DRAIN_CYCLES. CHECK follows after X*Y cycles, and `finished` rises one cycle later.
- **Timeout latency:** `finished` rises the cycle after the TIMEOUT-th RUN cycle.
- **Output registration:** all outputs are registered, with no combinational path from inputs to outputs. `receive_count` must be stable from DRAIN exit until CHECK.

## Test plan
- **Normal run:** X=2, Y=2, numPackets=100, mask=4'b1111, stub returns 100 per PE and raises `mesh_done` after 500 cycles. Required: `start` is a single pulse, `expected_total`=400, `total_received`=400, `pass`=1, `timed_out`=0, `cycle_count`=500, `finished` rises DRAIN_CYCLES+4+1 cycles after `mesh_done`.
- **Packet loss:** mask=4'b0101, counts {100, 0, 99, 0}. Required: `expected_total`=200, `total_received`=199, `pass`=0.
- **Timeout:** TIMEOUT=50, `mesh_done` held low. Required: `finished` and `timed_out` high, `cycle_count`=50, `pass`=0, `enableSend`=0 in DONE.
- **Simultaneous done and timeout:** `mesh_done` rises exactly in RUN cycle 50 with TIMEOUT=50. Required: the block goes through DRAIN and `timed_out`=0.
- **Reset mid-run:** deassert `rstn` during DRAIN. Required: all outputs are immediately 0. After release, `go` runs a clean second run with results identical to the normal run.
- **`go` spam:** pulse `go` during RUN and SUM. Required: no restart, `cycle_count` unaffected. `go` in DONE clears the results and restarts.
